// File: rtl/cmd_encoder_if.sv
// Command-in / instruction-out stream bundle for cmd_encoder.
interface cmd_encoder_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [8:0]        in_cmd;
  logic [3:0]        in_cond;
  logic              in_imm;
  logic [3:0]        in_rn;
  logic [3:0]        in_rd;
  logic [11:0]       in_operand;
  logic [23:0]       in_br_offset;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output in_valid, in_cmd, in_cond, in_imm, in_rn, in_rd, in_operand, in_br_offset,
    output out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );

  modport slave (
    input  in_valid, in_cmd, in_cond, in_imm, in_rn, in_rd, in_operand, in_br_offset,
    input  out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );
endinterface

// File: rtl/cmd_encoder.sv
// Re-encodes a control bundle plus operand fields into a 32-bit instruction word,
// buffers it in a 2-entry FIFO and tags each emitted word with a sequential address.
module cmd_encoder #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  cmd_encoder_if.slave  bus,
  output logic          err_pulse,
  output logic [7:0]    err_count,
  output logic          wrapped
);

  localparam int unsigned WORD_W = 32;

  logic              wb_en_c, mem_r_c, mem_w_c, b_c, s_c;
  logic [3:0]        exe_c;
  logic              dp_ok_c, rn_zero_c, rd_zero_c, need_s_c;
  logic [3:0]        dp_op_c;
  logic              legal_c;
  logic [WORD_W-1:0] instr_c;
  logic              accept_c, push_c, pop_c;

  logic [1:0]        count_q, count_d;
  logic [WORD_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wrapped_q, wrapped_d;
  logic              err_pulse_q, err_pulse_d;
  logic [7:0]        err_count_q, err_count_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;

  assign {wb_en_c, mem_r_c, mem_w_c, exe_c, b_c, s_c} = bus.in_cmd;

  // Combinational encode of the presented command; legal_c flags encodable bundles.
  always_comb begin
    dp_ok_c   = 1'b0;
    dp_op_c   = 4'h0;
    rn_zero_c = 1'b0;
    rd_zero_c = 1'b0;
    need_s_c  = 1'b0;
    legal_c   = 1'b0;
    instr_c   = '0;

    case ({exe_c, wb_en_c})
      5'b0001_1: begin dp_ok_c = 1'b1; dp_op_c = 4'b1101; rn_zero_c = 1'b1; end
      5'b1001_1: begin dp_ok_c = 1'b1; dp_op_c = 4'b1111; rn_zero_c = 1'b1; end
      5'b0010_1: begin dp_ok_c = 1'b1; dp_op_c = 4'b0100; end
      5'b0011_1: begin dp_ok_c = 1'b1; dp_op_c = 4'b0101; end
      5'b0100_1: begin dp_ok_c = 1'b1; dp_op_c = 4'b0010; end
      5'b0101_1: begin dp_ok_c = 1'b1; dp_op_c = 4'b0110; end
      5'b0110_1: begin dp_ok_c = 1'b1; dp_op_c = 4'b0000; end
      5'b0111_1: begin dp_ok_c = 1'b1; dp_op_c = 4'b1100; end
      5'b1000_1: begin dp_ok_c = 1'b1; dp_op_c = 4'b0001; end
      5'b0100_0: begin dp_ok_c = 1'b1; dp_op_c = 4'b1010; rd_zero_c = 1'b1; need_s_c = 1'b1; end
      5'b0110_0: begin dp_ok_c = 1'b1; dp_op_c = 4'b1000; rd_zero_c = 1'b1; need_s_c = 1'b1; end
      default: ;
    endcase

    if (b_c) begin
      if (!wb_en_c && !mem_r_c && !mem_w_c) begin
        legal_c = 1'b1;
        instr_c = {bus.in_cond, 4'b1010, bus.in_br_offset};
      end
    end else if (!mem_r_c && !mem_w_c) begin
      if (dp_ok_c && (!need_s_c || s_c)) begin
        legal_c = 1'b1;
        instr_c = {bus.in_cond, 2'b00, bus.in_imm, dp_op_c, s_c,
                   rn_zero_c ? 4'h0 : bus.in_rn, rd_zero_c ? 4'h0 : bus.in_rd,
                   bus.in_operand};
      end
    end else if (wb_en_c && mem_r_c && !mem_w_c && exe_c == 4'b0010 && s_c) begin
      legal_c = 1'b1;
      instr_c = {bus.in_cond, 2'b01, 1'b0, 4'b0100, 1'b1, bus.in_rn, bus.in_rd, bus.in_operand};
    end else if (!wb_en_c && !mem_r_c && mem_w_c && exe_c == 4'b0010 && !s_c) begin
      legal_c = 1'b1;
      instr_c = {bus.in_cond, 2'b01, 1'b0, 4'b0100, 1'b0, bus.in_rn, bus.in_rd, bus.in_operand};
    end
  end

  assign accept_c = bus.in_valid & in_ready_q;
  assign push_c   = accept_c & legal_c;
  assign pop_c    = out_valid_q & bus.out_ready;

  // FIFO kept as head/tail registers so the head drives out_instr directly.
  always_comb begin
    count_d     = count_q;
    head_d      = head_q;
    tail_d      = tail_q;
    addr_d      = addr_q;
    wrapped_d   = wrapped_q;
    err_pulse_d = accept_c & ~legal_c;
    err_count_d = err_count_q;

    if (pop_c && push_c) begin
      head_d = instr_c;
    end else if (pop_c) begin
      head_d  = tail_q;
      count_d = count_q - 2'd1;
    end else if (push_c) begin
      if (count_q == 2'd0) head_d = instr_c;
      else                 tail_d = instr_c;
      count_d = count_q + 2'd1;
    end

    if (pop_c) begin
      addr_d = addr_q + ADDR_W'(1);
      if (addr_q == '1) wrapped_d = 1'b1;
    end

    if (err_pulse_d && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;

    in_ready_d  = (count_d != 2'd2);
    out_valid_d = (count_d != 2'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= 2'd0;
      head_q      <= '0;
      tail_q      <= '0;
      addr_q      <= ADDR_W'(BASE_ADDR);
      wrapped_q   <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= 8'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      addr_q      <= addr_d;
      wrapped_q   <= wrapped_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = head_q;
  assign bus.out_addr  = addr_q;
  assign err_pulse     = err_pulse_q;
  assign err_count     = err_count_q;
  assign wrapped       = wrapped_q;

endmodule

// File: tb/tb_cmd_encoder.sv
// Randomized and directed bench for cmd_encoder against a queue-based reference model.
module tb_cmd_encoder;

  localparam int unsigned ADDR_W = 2;

  logic       clk;
  logic       rst_n;
  logic       err_pulse;
  logic [7:0] err_count;
  logic       wrapped;

  cmd_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  cmd_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .wrapped   (wrapped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;

  logic [31:0] exp_q[$];
  int          exp_addr;
  bit          exp_wrap;
  bit          exp_err_pulse;
  int          exp_err_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference encoder: whole-bundle pattern matching against the encoding rules.
  function automatic void ref_encode(input logic [8:0] cmd, input logic [3:0] cond,
                                     input logic imm, input logic [3:0] rn, input logic [3:0] rd,
                                     input logic [11:0] opnd, input logic [23:0] off,
                                     output bit ok, output logic [31:0] w);
    bit wb, mr, mw, b, s;
    logic [3:0] exe;
    int op;
    bit cmp_like, mov_like;
    wb = cmd[8]; mr = cmd[7]; mw = cmd[6]; exe = cmd[5:2]; b = cmd[1]; s = cmd[0];
    ok = 0; w = 32'h0; op = -1; cmp_like = 0; mov_like = 0;
    if (b) begin
      if (!wb && !mr && !mw) begin ok = 1; w = {cond, 4'hA, off}; end
    end else if (cmd == 9'b1_1_0_0010_0_1) begin
      ok = 1; w = {cond, 8'h49, rn, rd, opnd};
    end else if (cmd == 9'b0_0_1_0010_0_0) begin
      ok = 1; w = {cond, 8'h48, rn, rd, opnd};
    end else if (!mr && !mw) begin
      if (wb) begin
        case (exe)
          4'h1: begin op = 13; mov_like = 1; end
          4'h9: begin op = 15; mov_like = 1; end
          4'h2: op = 4;
          4'h3: op = 5;
          4'h4: op = 2;
          4'h5: op = 6;
          4'h6: op = 0;
          4'h7: op = 12;
          4'h8: op = 1;
          default: op = -1;
        endcase
      end else if (s) begin
        if (exe == 4'h4) begin op = 10; cmp_like = 1; end
        if (exe == 4'h6) begin op = 8;  cmp_like = 1; end
      end
      if (op >= 0) begin
        ok = 1;
        w = (32'(cond) << 28) | (32'(imm) << 25) | (32'(op) << 21) | (32'(s) << 20)
          | (mov_like ? 32'h0 : 32'(rn) << 16) | (cmp_like ? 32'h0 : 32'(rd) << 12)
          | 32'(opnd);
      end
    end
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_addr = 0;
    exp_wrap = 0;
    exp_err_pulse = 0;
    exp_err_cnt = 0;
  endtask

  task automatic check_outputs();
    chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
    chk("in_ready", 32'(bus.in_ready), 32'(exp_q.size() != 2));
    if (exp_q.size() != 0) chk("out_instr", bus.out_instr, exp_q[0]);
    chk("out_addr", 32'(bus.out_addr), 32'(exp_addr));
    chk("err_pulse", 32'(err_pulse), 32'(exp_err_pulse));
    chk("err_count", 32'(err_count), 32'(exp_err_cnt));
    chk("wrapped", 32'(wrapped), 32'(exp_wrap));
  endtask

  // Advance one clock with the inputs currently driven, update model, check at negedge.
  task automatic tick();
    bit acc, pop, ok;
    logic [31:0] w;
    acc = bus.in_valid && (exp_q.size() != 2);
    pop = (exp_q.size() != 0) && bus.out_ready;
    ref_encode(bus.in_cmd, bus.in_cond, bus.in_imm, bus.in_rn, bus.in_rd,
               bus.in_operand, bus.in_br_offset, ok, w);
    @(posedge clk);
    if (pop) begin
      void'(exp_q.pop_front());
      if (exp_addr == (1 << ADDR_W) - 1) exp_wrap = 1;
      exp_addr = (exp_addr + 1) % (1 << ADDR_W);
    end
    if (acc && ok) exp_q.push_back(w);
    exp_err_pulse = acc && !ok;
    if (exp_err_pulse && exp_err_cnt != 255) exp_err_cnt++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive(input logic [8:0] cmd, input logic [3:0] cond, input logic imm,
                       input logic [3:0] rn, input logic [3:0] rd, input logic [11:0] opnd,
                       input logic [23:0] off);
    bus.in_valid = 1'b1; bus.in_cmd = cmd; bus.in_cond = cond; bus.in_imm = imm;
    bus.in_rn = rn; bus.in_rd = rd; bus.in_operand = opnd; bus.in_br_offset = off;
  endtask

  task automatic send(input logic [8:0] cmd, input logic [3:0] cond, input logic imm,
                      input logic [3:0] rn, input logic [3:0] rd, input logic [11:0] opnd,
                      input logic [23:0] off);
    drive(cmd, cond, imm, rn, rd, opnd, off);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic random_cmd();
    logic [8:0] cmd;
    logic [3:0] exe;
    int k;
    k = $urandom_range(0, 3);
    case (k)
      0: cmd = 9'($urandom);
      1: begin
        exe = 4'($urandom_range(1, 9));
        cmd = {1'($urandom), 2'b00, exe, 1'b0, 1'($urandom)};
      end
      2: cmd = ($urandom_range(0, 1) == 0) ? 9'b1_1_0_0010_0_1 : 9'b0_0_1_0010_0_0;
      default: cmd = {3'b000, 4'($urandom), 1'b1, 1'($urandom)};
    endcase
    drive(cmd, 4'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
          12'($urandom), 24'($urandom));
    bus.in_valid = 1'($urandom_range(0, 3) != 0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_cmd = '0; bus.in_cond = '0; bus.in_imm = 1'b0; bus.in_rn = '0;
    bus.in_rd = '0; bus.in_operand = '0; bus.in_br_offset = '0;
    model_reset();
    #12;
    chk("rst_instr", bus.out_instr, 32'h0);
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Directed encodings with the consumer always ready.
    bus.out_ready = 1'b1;
    send(9'b1_0_0_0010_0_0, 4'hE, 1'b1, 4'd1, 4'd2, 12'h005, 24'h0);
    chk("add_word", bus.out_instr, 32'hE2812005);
    chk("add_addr", 32'(bus.out_addr), 32'd0);
    send(9'b0_0_0_0100_0_1, 4'hE, 1'b0, 4'd3, 4'd7, 12'h004, 24'h0);
    chk("cmp_word", bus.out_instr, 32'hE1530004);
    send(9'b0_0_0_0100_0_0, 4'hE, 1'b0, 4'd3, 4'd7, 12'h004, 24'h0);
    chk("cmp_s0_pulse", 32'(err_pulse), 32'd1);
    chk("cmp_s0_count", 32'(err_count), 32'd1);
    send(9'b1_1_0_0010_0_1, 4'hE, 1'b0, 4'd0, 4'd1, 12'h008, 24'h0);
    chk("ldr_word", bus.out_instr, 32'hE4901008);
    send(9'b0_0_0_0000_1_0, 4'hE, 1'b0, 4'd0, 4'd0, 12'h000, 24'hFFFFFE);
    chk("b_word", bus.out_instr, 32'hEAFFFFFE);
    chk("b_addr", 32'(bus.out_addr), 32'd3);
    tick();
    chk("wrap_set", 32'(wrapped), 32'd1);

    // Backpressure: third command held until space frees up.
    bus.out_ready = 1'b0;
    drive(9'b1_0_0_0111_0_0, 4'h0, 1'b0, 4'd4, 4'd5, 12'h111, 24'h0); tick();
    drive(9'b1_0_0_1000_0_1, 4'h1, 1'b1, 4'd6, 4'd7, 12'h222, 24'h0); tick();
    drive(9'b0_0_1_0010_0_0, 4'h2, 1'b0, 4'd8, 4'd9, 12'h333, 24'h0); tick();
    chk("bp_ready_low", 32'(bus.in_ready), 32'd0);
    tick();
    bus.out_ready = 1'b1;
    tick(); tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    chk("bp_drained", 32'(bus.out_valid), 32'd0);

    // Reset with two words buffered.
    bus.out_ready = 1'b0;
    send(9'b1_0_0_0010_0_0, 4'h3, 1'b0, 4'd1, 4'd1, 12'h001, 24'h0);
    send(9'b1_0_0_0011_0_0, 4'h4, 1'b0, 4'd2, 4'd2, 12'h002, 24'h0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(bus.out_valid), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs();
    chk("rst_mid_addr", 32'(bus.out_addr), 32'd0);
    chk("rst_mid_errs", 32'(err_count), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      random_cmd();
      bus.out_ready = 1'($urandom_range(0, 2) != 0);
      tick();
    end

    // Error counter saturation.
    for (int i = 0; i < 270; i++) begin
      drive(9'b1_1_1_0000_0_0, 4'($urandom), 1'b0, 4'd0, 4'd0, 12'h0, 24'h0);
      bus.out_ready = 1'($urandom);
      tick();
    end
    chk("err_sat", 32'(err_count), 32'd255);
    bus.in_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cmd_encoder.md
Name: cmd_encoder

Overview:
- Inverse of the ID-stage control decode: accepts a 9-bit control bundle plus operand fields and re-encodes a 32-bit instruction word.
- The control bundle layout is {WB_EN, MEM_R_EN, MEM_W_EN, EXE_CMD[3:0], B, S}.
- Encoded words are buffered in a 2-entry FIFO and emitted with sequential instruction-memory word addresses.
- Used by the program loader and by the self-check bench to generate instruction images from control-level descriptions.

Parameters:
ADDR_W, 10, width of instruction-memory word address.
BASE_ADDR, 0, first address emitted after reset.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  command present.
in_ready  out  1  encoder can accept; equals (fifo_count != 2).
in_cmd  in  9  {WB_EN, MEM_R_EN, MEM_W_EN, EXE_CMD[3:0], B, S}.
in_cond  in  4  condition field.
in_imm  in  1  I bit for data-processing.
in_rn  in  4  first source register.
in_rd  in  4  destination register.
in_operand  in  12  shifter operand or memory offset.
in_br_offset  in  24  branch offset.
out_valid  out  1  FIFO head valid.
out_ready  in  1  consumer accepts head.
out_instr  out  32  encoded word at FIFO head.
out_addr  out  ADDR_W  address for out_instr.
err_pulse  out  1  one-cycle pulse: previous accepted command was unencodable.
err_count  out  8  saturating count of rejected commands.
wrapped  out  1  sticky: address counter has wrapped.

Behaviour:
- Reset (async, rst_n=0):
  - FIFO emptied; out_valid=0, out_instr=0.
  - out_addr=BASE_ADDR; err_pulse=0; err_count=0; wrapped=0; in_ready=1.
  - Reset mid-operation discards buffered words.
- Word format:
  - [31:28] cond.
  - [27:26] mode.
  - [25] I.
  - [24:21] opcode.
  - [20] S.
  - [19:16] Rn.
  - [15:12] Rd.
  - [11:0] operand.
- Encoding is combinational on inputs. Legal cases:
  - Data-processing, mode 00, I=in_imm, requires MEM_R_EN=MEM_W_EN=B=0. EXE_CMD/WB_EN map as follows:
    - 0001/1 -> MOV 1101, Rn forced 0.
    - 1001/1 -> MVN 1111, Rn forced 0.
    - 0010/1 -> ADD 0100.
    - 0011/1 -> ADC 0101.
    - 0100/1 -> SUB 0010.
    - 0101/1 -> SBC 0110.
    - 0110/1 -> AND 0000.
    - 0111/1 -> ORR 1100.
    - 1000/1 -> EOR 0001.
    - 0100/0 -> CMP 1010, requires S=1, Rd forced 0.
    - 0110/0 -> TST 1000, requires S=1, Rd forced 0.
  - LDR:
    - Requires WB_EN=1, MEM_R_EN=1, MEM_W_EN=0, EXE_CMD=0010, S=1, B=0.
    - Encoding: mode 01, I=0, opcode 0100, S=1.
  - STR:
    - Requires WB_EN=0, MEM_R_EN=0, MEM_W_EN=1, EXE_CMD=0010, S=0, B=0.
    - Encoding: mode 01, I=0, opcode 0100, S=0.
  - Branch:
    - Requires B=1 with WB_EN=MEM_R_EN=MEM_W_EN=0; EXE_CMD and S are ignored.
    - Encoding: [27:24]=1010, [23:0]=in_br_offset.
- Unencodable commands: any other combination is an error.
- Accept: a handshake occurs on in_valid & in_ready at a rising edge.
  - Legal command: the word is pushed into the FIFO.
  - Illegal command: the handshake still completes but nothing is pushed. err_pulse=1 the next cycle; err_count increments and saturates at 255.
- Latency: accepted at edge N -> out_valid=1 after edge N, if the FIFO was empty.
- FIFO (2 entries):
  - Pop occurs on out_valid & out_ready.
  - Push and pop in the same cycle at count 1: count stays 1 and the head updates to the new word.
  - At count 2 in_ready=0; no push-through.
  - out_instr holds stable while out_valid=1 and out_ready=0.
- Address:
  - out_addr increments by 1 on each pop, mod 2^ADDR_W.
  - On increment from all-ones to 0, wrapped is set and stays set until reset.
  - Rejected commands consume no address.

Test Plan:
- ADD, cond=E, I=1, Rn=1, Rd=2, operand=0x005, cmd={1,0,0,0010,0,0}, out_ready=1 -> out_instr=0xE2812005 at out_addr=0 one cycle after accept.
- CMP, cond=E, I=0, Rn=3, Rd=7, operand=0x004, cmd={0,0,0,0100,0,1} -> 0xE1530004 (Rd forced 0). The same command with S=0 -> no word, err_pulse one cycle, err_count=1.
- LDR, cond=E, Rn=0, Rd=1, operand=0x008, cmd={1,1,0,0010,0,1} -> 0xE4901008. Branch, cond=E, cmd={0,0,0,0000,1,0}, offset=0xFFFFFE -> 0xEAFFFFFE at the next address.
- Backpressure: out_ready=0, three back-to-back legal commands -> in_ready drops after 2 accepts and the third is held. Raise out_ready -> words emitted in order at addresses 0, 1, 2, with no loss or duplication.
- With ADDR_W=2: five legal commands -> addresses 0,1,2,3,0; wrapped=1 after the fifth pop. Assert rst_n=0 with 2 words buffered -> out_valid=0 immediately, and out_addr=0, err_count=0 after release.
